// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : MiniUART register offsets, LSR bit indices and sequencer states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_LSR  = 3'd5;
    localparam logic [2:0] OFF_DIVR = 3'd6;
    localparam logic [2:0] OFF_DIVT = 3'd7;

    localparam int LSR_RXRDY = 0;
    localparam int LSR_THRE  = 5;

    typedef enum logic [2:0] {
        ST_INIT_T = 3'd0,
        ST_INIT_R = 3'd1,
        ST_IDLE   = 3'd2,
        ST_POLL   = 3'd3,
        ST_WR     = 3'd4,
        ST_RD     = 3'd5,
        ST_GAP    = 3'd6
    } seq_state_t;

    // RX wins over TX so a byte waiting in the UART is never starved.
    function automatic seq_state_t poll_next(
        input logic i_rx_rdy,
        input logic i_thre,
        input logic i_rx_full,
        input logic i_fifo_empty
    );
        if (i_rx_rdy && !i_rx_full)
            return ST_RD;
        else if (i_thre && !i_fifo_empty)
            return ST_WR;
        return ST_GAP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_wb_sequencer_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with wrapping pointers and an extra count bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: empty/full are governed by the count alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_wb_sequencer.sv
// ============================================================================
// Module   : uart_wb_sequencer
// Brief    : WISHBONE master that programs the MiniUART divisors, then polls
//            LSR to move TX FIFO bytes out and received bytes in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_wb_sequencer
    import uart_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] DIVT_INIT = 32'h9,
    parameter logic [31:0] DIVR_INIT = 32'h9,
    parameter int          POLL_GAP  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic [2:0]  off_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        stb_o,
    output logic        we_o,
    input  logic        ack_i
);

    localparam logic [7:0] c_POLL_LAST = 8'(POLL_GAP - 1);

    seq_state_t r_state;
    logic [7:0] r_poll_cnt;
    logic [7:0] w_fifo_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_done;
    logic       w_fifo_pop;
    logic       w_unused_dat;

    assign tx_ready     = ~w_fifo_full;
    assign w_done       = stb_o && ack_i;
    assign w_fifo_pop   = (r_state == ST_WR) && w_done;
    assign w_unused_dat = ^dat_i[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_valid && tx_ready),
        .i_data  (tx_data),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Each bus state raises stb on its first cycle and drops it on the
    // completing edge, which guarantees a low cycle between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT_T;
            r_poll_cnt <= '0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            off_o      <= '0;
            dat_o      <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            init_done  <= 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (r_state)
                ST_INIT_T: begin
                    if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        off_o <= OFF_DIVT;
                        dat_o <= DIVT_INIT;
                    end else if (ack_i) begin
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                        r_state <= ST_INIT_R;
                    end
                end

                ST_INIT_R: begin
                    if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        off_o <= OFF_DIVR;
                        dat_o <= DIVR_INIT;
                    end else if (ack_i) begin
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        init_done <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end

                ST_GAP: r_state <= ST_IDLE;

                ST_IDLE: begin
                    if (!w_fifo_empty || (r_poll_cnt == c_POLL_LAST)) begin
                        r_poll_cnt <= '0;
                        r_state    <= ST_POLL;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 8'd1;
                    end
                end

                ST_POLL: begin
                    if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        off_o <= OFF_LSR;
                        dat_o <= '0;
                    end else if (ack_i) begin
                        stb_o   <= 1'b0;
                        r_state <= poll_next(dat_i[LSR_RXRDY], dat_i[LSR_THRE],
                                             rx_valid, w_fifo_empty);
                    end
                end

                ST_RD: begin
                    if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        off_o <= OFF_DATA;
                        dat_o <= '0;
                    end else if (ack_i) begin
                        stb_o    <= 1'b0;
                        rx_data  <= dat_i[7:0];
                        rx_valid <= 1'b1;
                        r_state  <= ST_GAP;
                    end
                end

                ST_WR: begin
                    if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        off_o <= OFF_DATA;
                        dat_o <= {24'h0, w_fifo_head};
                    end else if (ack_i) begin
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end

                default: begin
                    stb_o   <= 1'b0;
                    we_o    <= 1'b0;
                    r_state <= ST_INIT_T;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_wb_sequencer.sv
// ============================================================================
// Module   : tb_uart_wb_sequencer
// Brief    : Randomised bench with a transaction-level UART/bus reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_wb_sequencer;
    import uart_pkg::*;

    localparam int DEPTH    = 4;
    localparam int POLL_GAP = 16;

    localparam int EXP_INIT_T = 0;
    localparam int EXP_INIT_R = 1;
    localparam int EXP_LSR    = 2;
    localparam int EXP_RD     = 3;
    localparam int EXP_WR     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done;
    logic [2:0]  off_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        stb_o;
    logic        we_o;
    logic        ack_i;

    int ack_lat = 0;
    int wait_cnt;

    // Reference model: expected next transfer, queued TX bytes, UART RX side.
    logic [7:0] q[$];
    logic [7:0] rxq[$];
    logic [7:0] rx_sent[$];
    int         exp_xfer;
    logic       m_rx_valid;
    logic [7:0] m_rx_data;
    logic       m_init_done;
    logic       thre = 1'b0;
    int         lsr_reads = 0;
    int         writes = 0;
    int         cyc = 0;
    int         last_lsr_cyc = 0;
    bit         prev_gap = 1'b0;
    bit         gap_clean = 1'b0;
    bit         prev_pend = 1'b0;
    bit         drop_due = 1'b0;
    bit         push_ok;
    bit         consume;
    logic       s_we;
    logic [2:0] s_off;
    logic [31:0] s_dat;
    logic [31:0] junk;
    logic [7:0]  lsr;

    int n_tests = 0;
    int n_fail  = 0;

    uart_wb_sequencer #(
        .DEPTH     (DEPTH),
        .DIVT_INIT (32'h9),
        .DIVR_INIT (32'h9),
        .POLL_GAP  (POLL_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .init_done (init_done),
        .off_o     (off_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .ack_i     (ack_i)
    );

    always #5 clk = ~clk;

    assign ack_i = stb_o && (wait_cnt >= ack_lat);

    always @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 0;
        else if (!stb_o || ack_i)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rxq.delete();
        rx_sent.delete();
        exp_xfer    = EXP_INIT_T;
        m_rx_valid  = 1'b0;
        m_rx_data   = 8'h0;
        m_init_done = 1'b0;
        prev_gap    = 1'b0;
        gap_clean   = 1'b0;
    endtask

    // Bus slave and checker; decisions made here apply at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
            drop_due  = 1'b0;
        end else begin
            cyc++;
            junk = $urandom;
            if (off_o == OFF_LSR) begin
                lsr    = junk[7:0] & 8'hDE;
                lsr[5] = thre;
                lsr[0] = (rxq.size() != 0);
                dat_i  = {junk[31:8], lsr};
            end else begin
                dat_i = {junk[31:8], (rxq.size() != 0) ? rxq[0] : junk[7:0]};
            end
            push_ok = (q.size() < DEPTH);
            consume = m_rx_valid && rx_ready;

            chk("tx_ready", tx_ready, push_ok);
            chk("rx_valid", rx_valid, m_rx_valid);
            chk("rx_data", rx_data, m_rx_data);
            chk("init_done", init_done, m_init_done);
            if (drop_due)
                chk("stb_drop", stb_o, 1'b0);
            if (prev_pend && stb_o)
                chk("bus_hold", {we_o, off_o, dat_o}, {s_we, s_off, s_dat});
            drop_due = 1'b0;
            if (ack_lat != 0 || q.size() != 0)
                gap_clean = 1'b0;

            if (stb_o && ack_i) begin
                case (exp_xfer)
                    EXP_INIT_T: begin
                        chk("init_divt", {we_o, off_o, dat_o}, {1'b1, OFF_DIVT, 32'h9});
                        exp_xfer = EXP_INIT_R;
                    end
                    EXP_INIT_R: begin
                        chk("init_divr", {we_o, off_o, dat_o}, {1'b1, OFF_DIVR, 32'h9});
                        m_init_done = 1'b1;
                        exp_xfer    = EXP_LSR;
                    end
                    EXP_LSR: begin
                        chk("poll_lsr", {we_o, off_o}, {1'b0, OFF_LSR});
                        lsr_reads++;
                        if (prev_gap && gap_clean)
                            chk("poll_gap", (cyc - last_lsr_cyc >= POLL_GAP) &&
                                            (cyc - last_lsr_cyc <= POLL_GAP + 4), 1'b1);
                        last_lsr_cyc = cyc;
                        gap_clean    = 1'b1;
                        prev_gap     = 1'b0;
                        if (dat_i[0] && !m_rx_valid)
                            exp_xfer = EXP_RD;
                        else if (dat_i[5] && q.size() != 0)
                            exp_xfer = EXP_WR;
                        else begin
                            exp_xfer = EXP_LSR;
                            prev_gap = 1'b1;
                        end
                    end
                    EXP_RD: begin
                        chk("rd_data", {we_o, off_o}, {1'b0, OFF_DATA});
                        m_rx_data  = dat_i[7:0];
                        m_rx_valid = 1'b1;
                        if (rxq.size() != 0)
                            void'(rxq.pop_front());
                        exp_xfer = EXP_LSR;
                    end
                    default: begin
                        if (q.size() != 0) begin
                            chk("wr_data", {we_o, off_o, dat_o}, {1'b1, OFF_DATA, 24'h0, q[0]});
                            void'(q.pop_front());
                        end
                        writes++;
                        exp_xfer = EXP_LSR;
                    end
                endcase
                drop_due  = 1'b1;
                prev_pend = 1'b0;
            end else begin
                prev_pend = stb_o;
                s_we      = we_o;
                s_off     = off_o;
                s_dat     = dat_o;
            end

            if (consume) begin
                m_rx_valid = 1'b0;
                if (rx_sent.size() != 0) begin
                    chk("rx_order", rx_data, rx_sent[0]);
                    void'(rx_sent.pop_front());
                end else begin
                    chk("rx_extra", 1'b1, 1'b0);
                end
            end
            if (tx_valid && push_ok) begin
                q.push_back(tx_data);
                gap_clean = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit done = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        if (!done)
            chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0)
                break;
            tick();
        end
        chk("drain", q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic wait_lsr(input int n);
        int target;
        target = lsr_reads + n;
        for (int i = 0; i < 3000; i++) begin
            if (lsr_reads >= target)
                break;
            tick();
        end
        chk("lsr_wait", lsr_reads >= target, 1'b1);
    endtask

    task automatic wait_init(input string tag);
        int cnt = 0;
        while (!init_done && cnt < 20) begin
            tick();
            cnt++;
        end
        chk(tag, cnt <= 6, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        logic [7:0] b;

        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_stb", stb_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_off", off_o, 3'd0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        rst = 1'b0;
        wait_init("init_latency");

        // Single byte with the transmitter idle.
        thre  = 1'b1;
        wbase = writes;
        push_byte(8'h12);
        wait_drain();
        chk("t2_writes", writes - wbase, 1);
        chk("t2_ready", tx_ready, 1'b1);

        // Transmitter busy for several polls, then two bytes in order.
        thre  = 1'b0;
        wbase = writes;
        push_byte(8'h55);
        push_byte(8'hAA);
        wait_lsr(3);
        chk("t3_nowrite", writes - wbase, 0);
        thre = 1'b1;
        wait_drain();
        chk("t3_writes", writes - wbase, 2);

        // Receive path with back-pressure from the consumer.
        rx_ready = 1'b0;
        rxq.push_back(8'h3C);
        rx_sent.push_back(8'h3C);
        for (int i = 0; i < 2000 && !rx_valid; i++) tick();
        chk("t4_rx_data", rx_data, 8'h3C);
        chk("t4_rx_valid", rx_valid, 1'b1);
        rxq.push_back(8'h77);
        rx_sent.push_back(8'h77);
        wait_lsr(3);
        chk("t4_held", rxq.size(), 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 2000 && rx_sent.size() != 0; i++) tick();
        chk("t4_consumed", rx_sent.size(), 0);
        rx_ready = 1'b0;
        tick();

        // Fill the FIFO, hold off a fifth byte, then drain.
        thre  = 1'b0;
        wbase = writes;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        tx_data  = 8'hA4;
        tx_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_full", tx_ready, 1'b0);
        tick();
        thre = 1'b1;
        push_byte(8'hA4);
        wait_drain();
        chk("t5_writes", writes - wbase, 5);

        // Randomised traffic with variable ack latency.
        for (int i = 0; i < 800; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            rx_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0)
                thre = ~thre;
            if ($urandom_range(0, 40) == 0 && rxq.size() < 3) begin
                b = 8'($urandom);
                rxq.push_back(b);
                rx_sent.push_back(b);
            end
            if ($urandom_range(0, 30) == 0 && !stb_o)
                ack_lat = $urandom_range(0, 2);
            tick();
        end
        tx_valid = 1'b0;
        thre     = 1'b1;
        rx_ready = 1'b1;
        ack_lat  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (q.size() == 0 && rx_sent.size() == 0 && rxq.size() == 0)
                break;
            tick();
        end
        chk("t6_drain", q.size() + rx_sent.size() + rxq.size(), 0);

        // Reset in the middle of a slow DATA write.
        ack_lat = 3;
        wbase   = writes;
        push_byte(8'h5A);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (stb_o && we_o && off_o == OFF_DATA)
                break;
        end
        chk("t7_in_wr", {stb_o, we_o, off_o}, {1'b1, 1'b1, OFF_DATA});
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t7_stb_drop", stb_o, 1'b0);
        ack_lat = 0;
        repeat (2) tick();
        rst = 1'b0;
        wait_init("t7_reinit");
        chk("t7_empty", tx_ready, 1'b1);
        repeat (40) tick();
        chk("t7_nowrite", writes - wbase, 0);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
